// File: rtl/systolic_array_mxn.sv
// systolic_array_mxn: output-stationary ROWSxCOLS signed GEMM tile engine.
// Define SYSTOLIC_SAT_EN for saturating accumulators; default wraps.
module systolic_array_mxn #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int K_W    = 8,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] a_in,
    input  logic [COLS*DATA_W-1:0] w_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLS*ACC_W-1:0]  out_data,
    output logic [ROW_W-1:0]       out_row,
    output logic                   out_last,
    output logic                   busy
);

    localparam int FL_N = ROWS + COLS - 1;
    localparam int FL_W = $clog2(FL_N + 1);

    typedef enum logic [1:0] {
        S_IDLE, S_LOAD, S_FLUSH, S_DRAIN
    } state_e;

    state_e state_q, state_d;
    logic [K_W-1:0]   rem_q, rem_d;
    logic [FL_W-1:0]  fl_q, fl_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic in_ready_q, in_ready_d;
    logic out_valid_q, out_valid_d;
    logic out_last_q, out_last_d;
    logic busy_q, busy_d;

    logic fire;
    logic clr;
    logic acc_en;

    assign fire   = in_valid && in_ready_q;
    assign clr    = (state_q == S_IDLE) && start;
    assign acc_en = (state_q == S_LOAD) || (state_q == S_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (k_len == '0) ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (fire && rem_q == K_W'(1)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fl_q == FL_W'(FL_N - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready && row_q == ROW_W'(ROWS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rem_d = rem_q;
        if (clr) begin
            rem_d = k_len;
        end else if (fire) begin
            rem_d = rem_q - K_W'(1);
        end
        fl_d = (state_q == S_FLUSH) ? fl_q + FL_W'(1) : '0;
        row_d = '0;
        if (state_q == S_DRAIN) begin
            row_d = row_q;
            if (out_ready) begin
                row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
            end
        end
    end

    // Handshake flags are decoded from the next state so they line up with it.
    always_comb begin
        in_ready_d  = (state_d == S_LOAD);
        out_valid_d = (state_d == S_DRAIN);
        busy_d      = (state_d != S_IDLE);
        out_last_d  = (state_d == S_DRAIN) && (row_d == ROW_W'(ROWS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            fl_q        <= '0;
            row_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            fl_q        <= fl_d;
            row_q       <= row_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign out_row   = row_q;

    logic signed [DATA_W-1:0] a_pe  [ROWS][COLS];
    logic signed [DATA_W-1:0] w_pe  [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_w [ROWS][COLS];

    // Row r line: first r stages are skew, the rest walk A across the row.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int N = r + COLS;
        logic signed [DATA_W-1:0] ln_q [N];
        logic signed [DATA_W-1:0] ln_d [N];

        always_comb begin
            ln_d[0] = fire ? a_in[r*DATA_W +: DATA_W] : '0;
            for (int j = 1; j < N; j++) begin
                ln_d[j] = ln_q[j-1];
            end
            if (clr) begin
                for (int j = 0; j < N; j++) begin
                    ln_d[j] = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ln_q <= '{default: '0};
            end else begin
                ln_q <= ln_d;
            end
        end

        for (genvar c = 0; c < COLS; c++) begin : g_tap
            assign a_pe[r][c] = ln_q[r+c];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int N = c + ROWS;
        logic signed [DATA_W-1:0] wl_q [N];
        logic signed [DATA_W-1:0] wl_d [N];

        always_comb begin
            wl_d[0] = fire ? w_in[c*DATA_W +: DATA_W] : '0;
            for (int j = 1; j < N; j++) begin
                wl_d[j] = wl_q[j-1];
            end
            if (clr) begin
                for (int j = 0; j < N; j++) begin
                    wl_d[j] = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wl_q <= '{default: '0};
            end else begin
                wl_q <= wl_d;
            end
        end

        for (genvar r = 0; r < ROWS; r++) begin : g_tap
            assign w_pe[r][c] = wl_q[c+r];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_pe_r
        for (genvar c = 0; c < COLS; c++) begin : g_pe_c
            logic signed [2*DATA_W-1:0] prod;
            logic signed [ACC_W-1:0]    acc_q, acc_d;
`ifdef SYSTOLIC_SAT_EN
            localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
            logic signed [ACC_W:0] sum;
`endif

            always_comb begin
                prod = a_pe[r][c] * w_pe[r][c];
`ifdef SYSTOLIC_SAT_EN
                sum = {acc_q[ACC_W-1], acc_q}
                    + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
                if (sum[ACC_W] != sum[ACC_W-1]) begin
                    acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
`else
                acc_d = acc_q + ACC_W'(prod);
`endif
                if (clr) begin
                    acc_d = '0;
                end else if (!acc_en) begin
                    acc_d = acc_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            assign acc_w[r][c] = acc_q;
        end
    end

    always_comb begin
        out_data = '0;
        for (int c = 0; c < COLS; c++) begin
            out_data[c*ACC_W +: ACC_W] = acc_w[row_q][c];
        end
    end

endmodule

// File: tb/tb_systolic_array_mxn.sv
// tb_systolic_array_mxn: model-checked bench for systolic_array_mxn.
// A 4x4 and a 2x3 instance share one operand stream and control.
`timescale 1ns/1ps
module tb_systolic_array_mxn;

    localparam int DW = 8;
    localparam int AW = 16;

`ifdef SYSTOLIC_SAT_EN
    localparam logic [63:0] EXT_LIT = 64'h7FFF_7FFF_7FFF_7FFF;
`else
    localparam logic [63:0] EXT_LIT = 64'h0;
`endif

    logic [63:0] ident_lit [4] = '{
        64'h0004_0003_0002_0001,
        64'h0008_0007_0006_0005,
        64'h000C_000B_000A_0009,
        64'h0010_000F_000E_000D
    };

    logic clk = 1'b0;
    logic rst;
    logic start, poke, in_valid, out_ready;
    logic [7:0] k_len;
    logic [4*DW-1:0] a_in0;
    logic [4*DW-1:0] w_in0;
    logic in_ready0, in_ready1, ov0, ov1, ol0, ol1, busy0, busy1;
    logic [4*AW-1:0] od0;
    logic [3*AW-1:0] od1;
    logic [1:0] or0;
    logic [0:0] or1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int s_cyc, tile_id, e_lat0, e_lat1, chk_mode, pin_on;
    bit bp_en;

    int am [4][8];
    int wm [8][4];
    logic [15:0] expc [4][4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_array_mxn #(
        .ROWS(4), .COLS(4), .DATA_W(DW), .ACC_W(AW), .K_W(8)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start | poke), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready0),
        .a_in(a_in0), .w_in(w_in0),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_row(or0), .out_last(ol0), .busy(busy0)
    );

    systolic_array_mxn #(
        .ROWS(2), .COLS(3), .DATA_W(DW), .ACC_W(AW), .K_W(8)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready1),
        .a_in(a_in0[2*DW-1:0]), .w_in(w_in0[3*DW-1:0]),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_row(or1), .out_last(ol1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack0(input int r);
        return {expc[r][3], expc[r][2], expc[r][1], expc[r][0]};
    endfunction

    function automatic logic [63:0] pack1(input int r);
        return {16'h0, expc[r][2], expc[r][1], expc[r][0]};
    endfunction

    // C = A*W summed in k order, clamped per step when saturating.
    task automatic build_model(input int k);
        longint acc;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                acc = 0;
                for (int i = 0; i < k; i++) begin
                    acc = acc + longint'(am[r][i]) * longint'(wm[i][c]);
`ifdef SYSTOLIC_SAT_EN
                    if (acc > 32767) acc = 32767;
                    if (acc < -32768) acc = -32768;
`endif
                end
                expc[r][c] = acc[15:0];
            end
        end
    endtask

    initial begin : compare
        int er0, er1, nb0, nb1, seen0, seen1;
        er0 = 0; er1 = 0; nb0 = 0; nb1 = 0; seen0 = 0; seen1 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                er0 = 0; er1 = 0; nb0 = 0; nb1 = 0;
            end else begin
                if (chk_mode == 1) begin
                    chk("rst_busy", {63'h0, busy0}, 64'h0);
                    chk("rst_in_ready", {63'h0, in_ready0}, 64'h0);
                    chk("rst_out_valid", {63'h0, ov0}, 64'h0);
                    chk("rst_out_row", {62'h0, or0}, 64'h0);
                    chk("rst_out_last", {63'h0, ol0}, 64'h0);
                    chk("rst_out_data", od0, 64'h0);
                    chk("rst_busy1", {63'h0, busy1}, 64'h0);
                    chk("rst_out_data1", {16'h0, od1}, 64'h0);
                end else if (chk_mode == 2) begin
                    chk("idle_busy", {63'h0, busy0}, 64'h0);
                    chk("idle_in_ready", {63'h0, in_ready0}, 64'h0);
                    chk("idle_out_valid", {63'h0, ov0}, 64'h0);
                    chk("idle_hold0", od0, pack0(0));
                    chk("idle_hold1", {16'h0, od1}, pack1(0));
                end
                if (ov0) begin
                    if (seen0 != tile_id) begin
                        seen0 = tile_id;
                        chk("lat0", 64'(cyc - s_cyc), 64'(e_lat0));
                    end
                    chk("row0", {62'h0, or0}, 64'(er0));
                    chk("last0", {63'h0, ol0}, {63'h0, er0 == 3});
                    chk("data0", od0, pack0(er0));
                    if (pin_on == 1) chk("pin_ident", pack0(er0), ident_lit[er0]);
                    if (pin_on == 2) chk("pin_ext", pack0(er0), EXT_LIT);
                    if (out_ready) begin
                        nb0++;
                        if (ol0) begin
                            chk("beats0", 64'(nb0), 64'd4);
                            nb0 = 0;
                        end
                        er0 = (er0 == 3) ? 0 : er0 + 1;
                    end
                end
                if (ov1) begin
                    if (seen1 != tile_id) begin
                        seen1 = tile_id;
                        chk("lat1", 64'(cyc - s_cyc), 64'(e_lat1));
                    end
                    chk("row1", {63'h0, or1}, 64'(er1));
                    chk("last1", {63'h0, ol1}, {63'h0, er1 == 1});
                    chk("data1", {16'h0, od1}, pack1(er1));
                    if (out_ready) begin
                        nb1++;
                        if (ol1) begin
                            chk("beats1", 64'(nb1), 64'd2);
                            nb1 = 0;
                        end
                        er1 = (er1 == 1) ? 0 : er1 + 1;
                    end
                end
            end
        end
    end

    initial begin : ready_drv
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            out_ready = bp_en ? (ph == 0) : 1'b1;
        end
    end

    task automatic drive_beat(input int i);
        in_valid = 1'b1;
        for (int r = 0; r < 4; r++) a_in0[r*DW +: DW] = 8'(am[r][i]);
        for (int c = 0; c < 4; c++) w_in0[c*DW +: DW] = 8'(wm[i][c]);
    endtask

    // Called at #1 after an edge with both instances idle.
    task automatic tile(input int k, input bit stall, input bit bp,
                        input bit poke_en, input bit junk,
                        input int lat0, input int lat1, input int pin);
        int n;
        bit poked;
        build_model(k);
        pin_on = pin;
        e_lat0 = lat0;
        e_lat1 = lat1;
        bp_en  = bp;
        start  = 1'b1;
        k_len  = 8'(k);
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
        tile_id++;
        for (int i = 0; i < k; i++) begin
            drive_beat(i);
            poke = poke_en && (i == 1);
            @(posedge clk); #1;
            poke = 1'b0;
            if (stall && i < k - 1) begin
                in_valid = 1'b0;
                a_in0 = $urandom;
                w_in0 = $urandom;
                @(posedge clk); #1;
            end
        end
        in_valid = junk;
        n = 0;
        poked = 1'b0;
        while ((busy0 || busy1) && n < 300) begin
            poke = poke_en && ov0 && !poked;
            if (poke) poked = 1'b1;
            if (junk) begin
                a_in0 = $urandom;
                w_in0 = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        poke = 1'b0;
        in_valid = 1'b0;
        bp_en = 1'b0;
        if (busy0 || busy1) begin
            $display("FAIL timeout: tile k=%0d still busy after %0d cycles", k, n);
            $fatal(1, "tile did not finish");
        end
    endtask

    task automatic idle_check();
        chk_mode = 2;
        @(posedge clk); #1;
        chk_mode = 0;
    endtask

    task automatic set_identity();
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 4; i++) am[r][i] = r * 4 + i + 1;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++) wm[i][c] = (i == c) ? 1 : 0;
    endtask

    task automatic set_random();
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 8; i++) am[r][i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < 4; c++) wm[i][c] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; poke = 1'b0; in_valid = 1'b0;
        k_len = '0; a_in0 = '0; w_in0 = '0;
        chk_mode = 0; pin_on = 0; bp_en = 1'b0;
        tile_id = 0; s_cyc = 0; e_lat0 = 0; e_lat1 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_mode = 1;
        @(posedge clk); #1;
        chk_mode = 0;

        set_identity();
        tile(4, 1'b0, 1'b0, 1'b1, 1'b0, 11, 8, 1);
        idle_check();

        tile(4, 1'b1, 1'b1, 1'b0, 1'b0, 14, 11, 1);

        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 4; i++) begin
                am[r][i] = -128;
                wm[i][r] = -128;
            end
        tile(4, 1'b0, 1'b0, 1'b0, 1'b0, 11, 8, 2);

        set_random();
        tile(3, 1'b0, 1'b1, 1'b0, 1'b0, 10, 7, 0);
        idle_check();

        tile(0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 4, 0);
        idle_check();

        set_identity();
        start = 1'b1;
        k_len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_beat(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_mode = 1;
        @(posedge clk); #1;
        chk_mode = 0;

        set_random();
        tile(4, 1'b0, 1'b0, 1'b0, 1'b0, 11, 8, 0);
        idle_check();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_array_mxn.md
# systolic_array_mxn

Parametrised output-stationary systolic matrix-multiply engine: computes C = A·W for an ROWS×K by K×COLS tile of signed operands. Operand skewing, tile sequencing, a ready/valid input stream and a row-serial ready/valid result drain are all handled internally. It is the successor to the fixed 4×4 array and sits between the operand buffers and the accumulator/writeback stage of the TPU datapath.

## Interface
- ROWS, 4: array rows; A operands per beat; ≥1
- COLS, 4: array columns; W operands per beat; ≥1
- DATA_W, 8: signed operand width
- ACC_W, 24: signed accumulator width; must be ≥ 2*DATA_W
- K_W, 8: width of k_len
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a tile; sampled only in IDLE
- k_len  in  K_W  tile depth K; latched on accepted start
- in_valid  in  1  operand beat valid
- in_ready  out  1  array accepting operand beats
- a_in  in  ROWS*DATA_W  A column k; row r at [r*DATA_W +: DATA_W]
- w_in  in  COLS*DATA_W  W row k; column c at [c*DATA_W +: DATA_W]
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts result row
- out_data  out  COLS*ACC_W  C[out_row][c] at [c*ACC_W +: ACC_W]
- out_row  out  max(1,$clog2(ROWS))  index of the row on out_data
- out_last  out  1  high with row ROWS-1
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: in_ready=0. When start=1: clear all accumulators and skew registers, latch K=k_len, go to LOAD (or to FLUSH if K=0).
- LOAD: in_ready=1. Each in_valid&&in_ready transfer is one beat. A cycle without a transfer injects zeros into every edge input. After the K-th transfer, go to FLUSH.
- Skew: a_in[r] is delayed r stages and w_in[c] is delayed c stages before entering the array. a moves right one PE per cycle; w moves down one PE per cycle.
- A beat accepted at edge t is accumulated into PE(r,c) at edge t+1+r+c. Zero bubbles contribute nothing, so stalls never corrupt results.
- FLUSH: inject zeros for ROWS+COLS-1 cycles (counter), then go to DRAIN.
- DRAIN: out_valid=1, starting at out_row=0. Each out_valid&&out_ready advances the row. The transfer with out_last=1 returns the FSM to IDLE.
- Accumulators hold their values until the next accepted start.
- start outside IDLE is ignored.
- in_valid outside LOAD is ignored.
- Arithmetic: full signed DATA_W×DATA_W product, sign-extended to ACC_W, added to the accumulator. By default the sum wraps modulo 2^ACC_W (see Configuration).
- Reset: rst at any time, including mid-tile, forces IDLE next edge. All accumulators, skew registers, counters and state clear. The tile is lost.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0, busy=0.
- in_ready, out_valid, out_row, out_last and busy are registered, decoded from state only. out_data is a mux of the accumulators by out_row.
- With start sampled at edge s and in_valid held high: beats are accepted at edges s+1…s+K, and out_valid first goes high after edge s+K+ROWS+COLS-1.
- Each input stall cycle adds exactly one cycle to this latency.
- Drain takes ROWS transfers; out_ready low holds out_data and out_row stable.
- Back-to-back tiles: start is accepted in the first IDLE cycle after the last drain transfer.

## Configuration
- SYSTOLIC_SAT_EN defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Once saturated, a value leaves the rail only through later additions of the opposite sign.
- SYSTOLIC_SAT_EN undefined: two's-complement wrap, no saturation logic.

## Test plan
- Multiply by identity: ROWS=COLS=4, K=4, W=identity, A[r][k]=r*4+k+1, continuous beats. Drained rows are {1,2,3,4},{5,6,7,8},…; out_valid first rises 1+4+7 cycles after start; out_last on row 3.
- Stalls and backpressure: same tile with in_valid toggling 1,0,1,0 and out_ready low for 3 cycles per row. Results are identical, latency grows by the number of stall cycles, and out_data/out_row are held stable while out_ready is low.
- Signed extremes: DATA_W=8, ACC_W=16, K=4, all A=-128, all W=-128. Every C=65536, which wraps to 0. With SYSTOLIC_SAT_EN, every C=32767.
- Non-square array: ROWS=2, COLS=3, K=3, random signed operands, compared against a golden model. Exactly 2 drain beats; out_row goes 0,1.
- K=0 and ignored inputs: start with k_len=0 goes IDLE→FLUSH→DRAIN and all rows are 0. start pulsed in LOAD/DRAIN is ignored.
- Reset mid-tile: assert rst during LOAD after 2 of 4 beats. The next cycle shows busy=0 and in_ready=0. A following full tile produces correct results with no residue.
